// File: rtl/usb_hid_pkg.sv
// ============================================================================
//  Module      : usb_hid_pkg
//  Description : Shared definitions for the ASCII-to-HID typer: HID usage
//                constants, modifier bits, typer FSM states and the
//                ASCII -> {modifier, usage, ok} mapping function.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_hid_pkg;

    // HID keyboard usage IDs (Keyboard/Keypad page)
    localparam logic [7:0] USAGE_A      = 8'h04;
    localparam logic [7:0] USAGE_1      = 8'h1E;
    localparam logic [7:0] USAGE_0      = 8'h27;
    localparam logic [7:0] USAGE_ENTER  = 8'h28;
    localparam logic [7:0] USAGE_SPACE  = 8'h2C;
    localparam logic [7:0] USAGE_MINUS  = 8'h2D;
    localparam logic [7:0] USAGE_COMMA  = 8'h36;
    localparam logic [7:0] USAGE_PERIOD = 8'h37;
    localparam logic [7:0] USAGE_SLASH  = 8'h38;

    // Modifier byte bits
    localparam logic [7:0] MOD_NONE     = 8'h00;
    localparam logic [7:0] MOD_LSHIFT   = 8'h02;

    // Typer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PRESS = 2'd2,
        ST_WAIT  = 2'd3
    } typer_state_t;

    // Result of mapping one ASCII byte
    typedef struct packed {
        logic [7:0] modifier;
        logic [7:0] usage;
        logic       ok;
    } hid_key_t;

    // Translate one ASCII byte; ok=0 marks bytes with no key equivalent
    function automatic hid_key_t ascii_to_hid(input logic [7:0] ch);
        hid_key_t k;
        k.modifier = MOD_NONE;
        k.usage    = 8'h00;
        k.ok       = 1'b0;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            k.usage = ch - 8'h61 + USAGE_A;
            k.ok    = 1'b1;
        end else if (ch >= 8'h41 && ch <= 8'h5A) begin
            k.usage    = ch - 8'h41 + USAGE_A;
            k.modifier = MOD_LSHIFT;
            k.ok       = 1'b1;
        end else if (ch >= 8'h31 && ch <= 8'h39) begin
            k.usage = ch - 8'h31 + USAGE_1;
            k.ok    = 1'b1;
        end else begin
            k.ok = 1'b1;
            case (ch)
                8'h30:        k.usage = USAGE_0;
                8'h0A, 8'h0D: k.usage = USAGE_ENTER;
                8'h20:        k.usage = USAGE_SPACE;
                8'h2D:        k.usage = USAGE_MINUS;
                8'h2C:        k.usage = USAGE_COMMA;
                8'h2E:        k.usage = USAGE_PERIOD;
                8'h2F:        k.usage = USAGE_SLASH;
                default:      k.ok    = 1'b0;
            endcase
        end
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_hid_char_fifo.sv
// ============================================================================
//  Module      : usb_hid_char_fifo
//  Description : Synchronous byte FIFO, 2^FIFO_AW entries. The head entry is
//                presented on rdata straight from the storage registers so
//                the consumer can capture it on the same edge it pops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_hid_char_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] C_DEPTH = DEPTH[FIFO_AW:0];

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // A push while full is only accepted when the head leaves in the same cycle
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_hid_ascii_typer.sv
// ============================================================================
//  Module      : usb_hid_ascii_typer
//  Description : Buffers ASCII bytes, maps each to a HID usage + modifier and
//                emits paced one-cycle key_request pulses for usb_hid_top.
//                Unsupported bytes are discarded and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_hid_ascii_typer
    import usb_hid_pkg::*;
#(
    parameter int FIFO_AW         = 4,
    parameter int INTERVAL_CYCLES = 6000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] key_value,
    output logic        key_request,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int CNT_W = $clog2(INTERVAL_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(INTERVAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typer_state_t     r_state;
    logic [7:0]       r_char_q;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_pop;
    logic [7:0]       w_fifo_rdata;
    hid_key_t         w_map;

    assign in_ready   = !w_fifo_full;
    assign w_fifo_pop = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_map      = ascii_to_hid(r_char_q);

    usb_hid_char_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .wdata (in_data),
        .pop   (w_fifo_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Fetch / map / press / pace sequencer with registered outputs.
    // WAIT lasts INTERVAL_CYCLES-1 cycles so that PRESS + WAIT + IDLE + FETCH
    // spaces consecutive presses exactly INTERVAL_CYCLES+2 cycles apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_char_q    <= 8'h00;
            r_wait_cnt  <= '0;
            key_value   <= 16'h0000;
            key_request <= 1'b0;
            drop_count  <= 8'h00;
        end else begin
            key_request <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_char_q <= w_fifo_rdata;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_map.ok) begin
                        key_value   <= {w_map.modifier, w_map.usage};
                        key_request <= 1'b1;
                        r_state     <= ST_PRESS;
                    end else begin
                        if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    r_wait_cnt <= C_CNT_LOAD;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt <= C_CNT_ONE) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - C_CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Activity flag, one cycle behind the state/occupancy it reflects
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= !w_fifo_empty || (r_state != ST_IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_hid_ascii_typer.sv
// ============================================================================
//  Module      : tb_usb_hid_ascii_typer
//  Description : Directed self-checking bench for usb_hid_ascii_typer with
//                INTERVAL_CYCLES=10 (press spacing 12 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_hid_ascii_typer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [15:0] key_value;
    logic        key_request;
    logic        busy;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          pulse_cyc[$];
    logic [15:0] pulse_val[$];

    usb_hid_ascii_typer #(
        .FIFO_AW         (4),
        .INTERVAL_CYCLES (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .key_value   (key_value),
        .key_request (key_request),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every press pulse with the edge index that started it
    always @(negedge clk) begin
        if (key_request) begin
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(key_value);
        end
    end

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_val.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    // Offer one byte, returning the edge index at which it was taken
    task automatic push_byte(input logic [7:0] b, output int acc, output bit stalled);
        int guard;
        guard    = 0;
        stalled  = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 1000) begin
            stalled = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: in_ready stayed %b, expected 1", in_ready);
        end
        @(posedge clk);
        acc = cyc + 1;
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (key_value !== 16'h0000) begin failures++; $display("FAIL reset_key_value: got %h expected 0000", key_value); end
        checks++; if (key_request !== 1'b0) begin failures++; $display("FAIL reset_key_request: got %b expected 0", key_request); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (drop_count !== 8'h00) begin failures++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        int acc;
        bit st;
        apply_reset();
        push_byte(8'h61, acc, st);
        wait_cycles(1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_high: got %b expected 1", busy); end
        wait_cycles(30);
        checks++; if (pulse_cyc.size() != 1) begin failures++; $display("FAIL single_count: got %0d expected 1", pulse_cyc.size()); end
        else begin
            checks++; if (pulse_cyc[0] != acc + 2) begin failures++; $display("FAIL single_latency: got %0d expected %0d", pulse_cyc[0] - acc, 2); end
            checks++; if (pulse_val[0] !== 16'h0004) begin failures++; $display("FAIL single_value: got %h expected 0004", pulse_val[0]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_low: got %b expected 0", busy); end
        checks++; if (key_value !== 16'h0004) begin failures++; $display("FAIL single_hold: got %h expected 0004", key_value); end
    endtask

    task automatic test_mixed();
        logic [7:0]  str [5] = '{8'h48, 8'h69, 8'h20, 8'h39, 8'h0A};
        logic [15:0] exp [5] = '{16'h020B, 16'h000C, 16'h002C, 16'h0026, 16'h0028};
        int acc0, acc;
        bit st;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_byte(str[i], acc, st);
            if (i == 0) acc0 = acc;
        end
        wait_cycles(80);
        checks++; if (pulse_cyc.size() != 5) begin failures++; $display("FAIL mixed_count: got %0d expected 5", pulse_cyc.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (pulse_val[i] !== exp[i]) begin failures++; $display("FAIL mixed_value[%0d]: got %h expected %h", i, pulse_val[i], exp[i]); end
                checks++; if (pulse_cyc[i] != acc0 + 2 + 12 * i) begin failures++; $display("FAIL mixed_time[%0d]: got %0d expected %0d", i, pulse_cyc[i] - acc0, 2 + 12 * i); end
            end
        end
    endtask

    task automatic test_full();
        int acc, first_stall;
        bit st;
        apply_reset();
        first_stall = -1;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h7A, acc, st);
            if (st && first_stall < 0) first_stall = i;
        end
        checks++; if (first_stall != 18) begin failures++; $display("FAIL full_first_stall: got %0d expected 18", first_stall); end
        wait_cycles(20 * 12 + 40);
        checks++; if (pulse_cyc.size() != 20) begin failures++; $display("FAIL full_count: got %0d expected 20", pulse_cyc.size()); end
        else begin
            for (int i = 0; i < 20; i++) begin
                checks++; if (pulse_val[i] !== 16'h001D) begin failures++; $display("FAIL full_value[%0d]: got %h expected 001d", i, pulse_val[i]); end
                if (i > 0) begin
                    checks++; if (pulse_cyc[i] - pulse_cyc[i-1] != 12) begin failures++; $display("FAIL full_spacing[%0d]: got %0d expected 12", i, pulse_cyc[i] - pulse_cyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_unsupported();
        logic [7:0] str [4] = '{8'h61, 8'h7E, 8'h00, 8'h62};
        int acc0, acc;
        bit st;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_byte(str[i], acc, st);
            if (i == 0) acc0 = acc;
        end
        wait_cycles(50);
        checks++; if (pulse_cyc.size() != 2) begin failures++; $display("FAIL unsup_count: got %0d expected 2", pulse_cyc.size()); end
        else begin
            checks++; if (pulse_val[0] !== 16'h0004) begin failures++; $display("FAIL unsup_value0: got %h expected 0004", pulse_val[0]); end
            checks++; if (pulse_val[1] !== 16'h0005) begin failures++; $display("FAIL unsup_value1: got %h expected 0005", pulse_val[1]); end
            checks++; if (pulse_cyc[1] - pulse_cyc[0] != 16) begin failures++; $display("FAIL unsup_spacing: got %0d expected 16", pulse_cyc[1] - pulse_cyc[0]); end
            checks++; if (pulse_cyc[0] != acc0 + 2) begin failures++; $display("FAIL unsup_latency: got %0d expected 2", pulse_cyc[0] - acc0); end
        end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL unsup_drop: got %0d expected 2", drop_count); end
        clear_log();
        for (int i = 0; i < 300; i++) begin
            push_byte(8'h7E, acc, st);
        end
        wait_cycles(60);
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
        checks++; if (pulse_cyc.size() != 0) begin failures++; $display("FAIL drop_no_pulse: got %0d expected 0", pulse_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit st;
        apply_reset();
        push_byte(8'h0D, acc, st);   // leaves a nonzero key_value (0028)
        wait_cycles(20);
        push_byte(8'h7E, acc, st);   // nonzero drop_count
        wait_cycles(5);
        for (int i = 0; i < 6; i++) begin
            push_byte(8'h61, acc, st);
        end
        // First 'a' is now in WAIT with five more buffered
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        checks++; if (key_value !== 16'h0000) begin failures++; $display("FAIL midrst_key_value: got %h expected 0000", key_value); end
        checks++; if (key_request !== 1'b0) begin failures++; $display("FAIL midrst_key_request: got %b expected 0", key_request); end
        checks++; if (drop_count !== 8'h00) begin failures++; $display("FAIL midrst_drop: got %0d expected 0", drop_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        wait_cycles(40);
        checks++; if (pulse_cyc.size() != 0) begin failures++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulse_cyc.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy_later: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1;
        bit st;
        apply_reset();
        push_byte(8'h63, acc0, st);
        push_byte(8'h64, acc1, st);   // lands on the edge the FSM pops 'c'
        checks++; if (acc1 != acc0 + 1) begin failures++; $display("FAIL b2b_accept: got %0d expected %0d", acc1 - acc0, 1); end
        checks++; if (dut.u_fifo.r_count !== 5'd1) begin failures++; $display("FAIL b2b_occupancy: got %0d expected 1", dut.u_fifo.r_count); end
        wait_cycles(30);
        checks++; if (pulse_cyc.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", pulse_cyc.size()); end
        else begin
            checks++; if (pulse_val[0] !== 16'h0006) begin failures++; $display("FAIL b2b_value0: got %h expected 0006", pulse_val[0]); end
            checks++; if (pulse_val[1] !== 16'h0007) begin failures++; $display("FAIL b2b_value1: got %h expected 0007", pulse_val[1]); end
            checks++; if (pulse_cyc[1] != acc0 + 14) begin failures++; $display("FAIL b2b_time: got %0d expected 14", pulse_cyc[1] - acc0); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_full();
        test_unsupported();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
